// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV64 core: operand forwarding, load-use stall,
// valid/ready on both sides and a branch-redirect flush.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [3:0]      id_aluop,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_op1_pc,
    input  logic            id_use_imm,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_rd_wen,
    input  logic            id_is_load,
    input  logic [XLEN-1:0] alu_result,
    input  logic            exmem_valid,
    input  logic            exmem_rd_wen,
    input  logic            exmem_is_load,
    input  logic [RA_W-1:0] exmem_rd_addr,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_valid,
    input  logic            memwb_rd_wen,
    input  logic [RA_W-1:0] memwb_rd_addr,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_aluop,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_rd_wen,
    output logic            ex_is_load
);

    typedef struct packed {
        logic [3:0]      aluop;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rd_addr;
        logic            rd_wen;
        logic            is_load;
    } payload_t;

    payload_t        q;
    payload_t        d;
    logic            vld;
    logic            stall;
    logic            xfer_in;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // x0 always reads as zero, whatever the register file returns.
    function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] a,
                                            input logic [XLEN-1:0] rf);
        if (a == '0)
            fwd = '0;
        else if (vld && q.rd_wen && !q.is_load && q.rd_addr == a)
            fwd = alu_result;
        else if (exmem_valid && exmem_rd_wen && !exmem_is_load && exmem_rd_addr == a)
            fwd = exmem_result;
        else if (memwb_valid && memwb_rd_wen && memwb_rd_addr == a)
            fwd = memwb_result;
        else
            fwd = rf;
    endfunction

    // The nearest writer of the register decides: a non-load in EX shadows a load behind it.
    function automatic logic load_hazard(input logic [RA_W-1:0] a);
        logic ex_hit;
        logic exmem_hit;
        ex_hit      = vld && q.rd_wen && q.rd_addr == a;
        exmem_hit   = exmem_valid && exmem_rd_wen && exmem_rd_addr == a;
        load_hazard = (a != '0) && (ex_hit ? q.is_load : (exmem_hit && exmem_is_load));
    endfunction

    always_comb begin
        fwd_rs1 = fwd(id_rs1_addr, id_rs1_data);
        fwd_rs2 = fwd(id_rs2_addr, id_rs2_data);
        stall   = (!id_op1_pc && load_hazard(id_rs1_addr)) ||
                  (!id_use_imm && load_hazard(id_rs2_addr));
    end

    assign id_ready = !flush && !stall && (!vld || ex_ready);
    assign xfer_in  = id_valid && id_ready;

    always_comb begin
        d.aluop   = id_aluop;
        d.op1     = id_op1_pc ? id_pc : fwd_rs1;
        d.op2     = id_use_imm ? id_imm : fwd_rs2;
        d.pc      = id_pc;
        d.rd_addr = id_rd_addr;
        d.rd_wen  = id_rd_wen;
        d.is_load = id_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (xfer_in) begin
            vld <= 1'b1;
            q   <= d;
        end else if (vld && ex_ready) begin
            vld <= 1'b0;
        end
    end

    assign ex_valid   = vld;
    assign ex_aluop   = q.aluop;
    assign ex_op1     = q.op1;
    assign ex_op2     = q.op2;
    assign ex_pc      = q.pc;
    assign ex_rd_addr = q.rd_addr;
    assign ex_rd_wen  = q.rd_wen;
    assign ex_is_load = q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected payloads queued on acceptance,
// compared when the stage hands an instruction downstream.
module tb_id_ex_stage;

    logic        clk, rst, flush, id_valid, id_ready;
    logic [3:0]  id_aluop;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm, alu_result;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_op1_pc, id_use_imm, id_rd_wen, id_is_load;
    logic        exmem_valid, exmem_rd_wen, exmem_is_load;
    logic [4:0]  exmem_rd_addr;
    logic [63:0] exmem_result;
    logic        memwb_valid, memwb_rd_wen;
    logic [4:0]  memwb_rd_addr;
    logic [63:0] memwb_result;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_aluop;
    logic [63:0] ex_op1, ex_op2, ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_wen, ex_is_load;

    typedef struct packed {
        logic [3:0]  aluop;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage #(.XLEN(64), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_aluop(id_aluop), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_op1_pc(id_op1_pc), .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr),
        .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .alu_result(alu_result),
        .exmem_valid(exmem_valid), .exmem_rd_wen(exmem_rd_wen), .exmem_is_load(exmem_is_load),
        .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_valid(memwb_valid), .memwb_rd_wen(memwb_rd_wen),
        .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluop(ex_aluop),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pc(ex_pc),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream monitor: every handshake out retires the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            checks++;
            got = {ex_aluop, ex_op1, ex_op2, ex_pc, ex_rd_addr, ex_rd_wen, ex_is_load};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h op1=%h op2=%h, none expected", ex_pc, ex_op1, ex_op2);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_payload: got op=%h op1=%h op2=%h pc=%h rd=%0d wen=%b ld=%b exp op=%h op1=%h op2=%h pc=%h rd=%0d wen=%b ld=%b",
                             got.aluop, got.op1, got.op2, got.pc, got.rd, got.wen, got.ld,
                             e.aluop, e.op1, e.op2, e.pc, e.rd, e.wen, e.ld);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] op, input logic [63:0] pc,
                            input logic [4:0] rs1, input logic [63:0] d1,
                            input logic [4:0] rs2, input logic [63:0] d2,
                            input logic [63:0] imm, input logic op1pc, input logic useimm,
                            input logic [4:0] rd, input logic wen, input logic ld);
        id_valid = v; id_aluop = op; id_pc = pc;
        id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2; id_rs2_data = d2;
        id_imm = imm; id_op1_pc = op1pc; id_use_imm = useimm;
        id_rd_addr = rd; id_rd_wen = wen; id_is_load = ld;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [63:0] op1, input logic [63:0] op2,
                            input logic [63:0] pc, input logic [4:0] rd, input logic wen, input logic ld);
        exp_t e;
        e = {op, op1, op2, pc, rd, wen, ld};
        sb.push_back(e);
    endtask

    task automatic clear_pipe();
        exmem_valid = 0; exmem_rd_wen = 0; exmem_is_load = 0; exmem_rd_addr = 0; exmem_result = 0;
        memwb_valid = 0; memwb_rd_wen = 0; memwb_rd_addr = 0; memwb_result = 0;
        alu_result = 0;
    endtask

    task automatic test_reset();
        rst = 0; flush = 0; ex_ready = 1;
        clear_pipe();
        drive_id(1, 4'h3, 64'h80, 0, 0, 0, 0, 64'h5, 0, 1, 2, 1, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (ex_valid !== 1'b0 || ex_op1 !== 64'h0 || ex_op2 !== 64'h0 || ex_pc !== 64'h0 ||
            ex_aluop !== 4'h0 || ex_rd_addr !== 5'h0 || ex_rd_wen !== 1'b0 || ex_is_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b op1=%h op2=%h pc=%h, expected all zero", ex_valid, ex_op1, ex_op2, ex_pc);
        end
        tick();
        rst = 1;
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", id_ready); end
        push_exp(4'h3, 64'h0, 64'h5, 64'h80, 2, 1, 0);
        tick();
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_first_latency: ex_valid=%b expected 1", ex_valid); end
        id_valid = 0;
        tick();
    endtask

    task automatic test_ex_fwd();
        ex_ready = 1;
        drive_id(1, 4'h1, 64'h100, 0, 0, 0, 0, 64'h10, 0, 1, 5, 1, 0);
        push_exp(4'h1, 64'h0, 64'h10, 64'h100, 5, 1, 0);
        tick();
        alu_result = 64'h10;
        drive_id(1, 4'h2, 64'h104, 5, 64'h55, 0, 64'hFF, 0, 0, 0, 6, 1, 0);
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL ex_fwd_ready: got %b expected 1", id_ready); end
        push_exp(4'h2, 64'h10, 64'h0, 64'h104, 6, 1, 0);
        tick();
        alu_result = 64'h20;
        drive_id(1, 4'h3, 64'h108, 6, 64'h66, 0, 0, 64'h4, 0, 1, 0, 1, 0);
        push_exp(4'h3, 64'h20, 64'h4, 64'h108, 0, 1, 0);
        tick();
        // EX writes x0: a reader of x0 still sees zero.
        alu_result = 64'h99;
        drive_id(1, 4'h4, 64'h10C, 0, 64'h77, 0, 64'h88, 0, 0, 0, 1, 0, 0);
        push_exp(4'h4, 64'h0, 64'h0, 64'h10C, 1, 0, 0);
        tick();
        id_valid = 0;
        tick(); tick();
        alu_result = 0;
    endtask

    task automatic test_priority();
        ex_ready = 1;
        exmem_valid = 1; exmem_rd_wen = 1; exmem_is_load = 0; exmem_rd_addr = 7; exmem_result = 64'hA;
        memwb_valid = 1; memwb_rd_wen = 1; memwb_rd_addr = 7; memwb_result = 64'hB;
        drive_id(1, 4'h5, 64'h200, 7, 64'hC, 0, 0, 64'h3, 0, 1, 1, 0, 0);
        push_exp(4'h5, 64'hA, 64'h3, 64'h200, 1, 0, 0);
        tick();
        exmem_valid = 0;
        drive_id(1, 4'h5, 64'h204, 7, 64'hC, 0, 0, 64'h3, 0, 1, 1, 0, 0);
        push_exp(4'h5, 64'hB, 64'h3, 64'h204, 1, 0, 0);
        tick();
        memwb_valid = 0;
        drive_id(1, 4'h5, 64'h208, 7, 64'hC, 0, 0, 64'h3, 0, 1, 1, 0, 0);
        push_exp(4'h5, 64'hC, 64'h3, 64'h208, 1, 0, 0);
        tick();
        drive_id(1, 4'h6, 64'h20C, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0);
        push_exp(4'h6, 64'h0, 64'h0, 64'h20C, 7, 1, 0);
        tick();
        // Non-load in EX is nearest producer: no stall despite a load to x7 in EX/MEM.
        alu_result = 64'h9;
        exmem_valid = 1; exmem_is_load = 1; exmem_result = 64'hDEAD;
        memwb_valid = 1;
        drive_id(1, 4'h7, 64'h210, 0, 0, 7, 64'hC, 0, 0, 0, 2, 1, 0);
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL nearest_no_stall: id_ready=%b expected 1", id_ready); end
        push_exp(4'h7, 64'h0, 64'h9, 64'h210, 2, 1, 0);
        tick();
        clear_pipe();
        id_valid = 0;
        tick(); tick();
    endtask

    task automatic test_load_use();
        ex_ready = 1;
        drive_id(1, 4'h8, 64'h300, 0, 0, 0, 0, 64'h8, 0, 1, 3, 1, 1);
        push_exp(4'h8, 64'h0, 64'h8, 64'h300, 3, 1, 1);
        tick();
        alu_result = 64'h1008;
        drive_id(1, 4'h9, 64'h304, 0, 0, 3, 64'h33, 0, 0, 0, 4, 1, 0);
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL load_use_stall_ex: id_ready=%b expected 0", id_ready); end
        tick();
        exmem_valid = 1; exmem_rd_wen = 1; exmem_is_load = 1; exmem_rd_addr = 3; exmem_result = 64'h0;
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL load_use_stall_exmem: id_ready=%b ex_valid=%b expected 0 0", id_ready, ex_valid);
        end
        tick();
        exmem_valid = 0;
        memwb_valid = 1; memwb_rd_wen = 1; memwb_rd_addr = 3; memwb_result = 64'h3333;
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL load_use_release: id_ready=%b expected 1", id_ready); end
        push_exp(4'h9, 64'h0, 64'h3333, 64'h304, 4, 1, 0);
        tick();
        clear_pipe();
        id_valid = 0;
        tick(); tick();
        // Same load, but the consumer takes neither register source.
        drive_id(1, 4'h8, 64'h308, 0, 0, 0, 0, 64'h8, 0, 1, 3, 1, 1);
        push_exp(4'h8, 64'h0, 64'h8, 64'h308, 3, 1, 1);
        tick();
        drive_id(1, 4'h9, 64'h30C, 3, 64'h31, 3, 64'h33, 64'h40, 1, 1, 4, 1, 0);
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL load_use_imm_no_stall: id_ready=%b expected 1", id_ready); end
        push_exp(4'h9, 64'h30C, 64'h40, 64'h30C, 4, 1, 0);
        tick();
        id_valid = 0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        ex_ready = 0;
        drive_id(1, 4'hA, 64'h400, 0, 0, 0, 0, 64'h11, 0, 1, 8, 1, 0);
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_empty_ready: id_ready=%b expected 1", id_ready); end
        push_exp(4'hA, 64'h0, 64'h11, 64'h400, 8, 1, 0);
        tick();
        drive_id(1, 4'hB, 64'h404, 0, 0, 0, 0, 64'h22, 0, 1, 9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_aluop !== 4'hA || ex_op2 !== 64'h11 ||
                ex_pc !== 64'h400 || ex_rd_addr !== 5'd8) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ready=%b valid=%b op=%h op2=%h pc=%h expected 0 1 a 11 400",
                         i, id_ready, ex_valid, ex_aluop, ex_op2, ex_pc);
            end
            tick();
        end
        ex_ready = 1;
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: id_ready=%b expected 1", id_ready); end
        push_exp(4'hB, 64'h0, 64'h22, 64'h404, 9, 1, 0);
        tick();
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 64'h404) begin
            errors++; $display("FAIL bp_no_bubble: valid=%b pc=%h expected 1 404", ex_valid, ex_pc);
        end
        id_valid = 0;
        tick(); tick();
    endtask

    task automatic test_flush();
        exp_t dropped;
        ex_ready = 0;
        drive_id(1, 4'hC, 64'h500, 0, 0, 0, 0, 64'h5, 0, 1, 10, 1, 0);
        push_exp(4'hC, 64'h0, 64'h5, 64'h500, 10, 1, 0);
        tick();
        drive_id(1, 4'hD, 64'h504, 0, 0, 0, 0, 64'h6, 0, 1, 11, 1, 0);
        flush = 1;
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: id_ready=%b expected 0", id_ready); end
        tick();
        flush = 0;
        id_valid = 0;
        dropped = sb.pop_back();
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: ex_valid=%b expected 0", ex_valid); end
        tick();
        // Async reset while an instruction is held under backpressure.
        drive_id(1, 4'hE, 64'h600, 0, 0, 0, 0, 64'h7, 0, 1, 12, 1, 0);
        push_exp(4'hE, 64'h0, 64'h7, 64'h600, 12, 1, 0);
        tick();
        id_valid = 0;
        #2 rst = 0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_op2 !== 64'h0 || ex_pc !== 64'h0) begin
            errors++; $display("FAIL reset_mid_stall: valid=%b op2=%h pc=%h expected 0 0 0", ex_valid, ex_op2, ex_pc);
        end
        dropped = sb.pop_back();
        #1 rst = 1;
        ex_ready = 1;
        tick(); tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_no_replay: ex_valid=%b expected 0", ex_valid); end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_flush();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
